led_seq_ctrl: RTL and testbench

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

---
 rtl/led_pkg.sv | 34 +++
 rtl/led_step_div.sv | 36 +++
 rtl/led_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_led_seq_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared encodings for the LED sequencer: display modes, controller states
// and the value each mode shows right after a configuration load.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_SHIFT = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [7:0] START_COUNT = 8'h00;
  localparam logic [7:0] START_SHIFT = 8'h01;
  localparam logic [7:0] START_BLINK = 8'h00;
  localparam logic [7:0] RST_PAT     = 8'hFF;

  function automatic logic [7:0] start_val(input mode_e mode, input logic [7:0] pat);
    logic [7:0] v;
    case (mode)
      MODE_COUNT: v = START_COUNT;
      MODE_SHIFT: v = START_SHIFT;
      MODE_BLINK: v = START_BLINK;
      default:    v = pat;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/led_step_div.sv
// Step prescaler: counts 0..div-1 while run is high and flags the last count.
// A divider of zero behaves as one, so every run cycle is a tick.
module led_step_div #(
  parameter int DIV_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             clear_i,
  input  logic             run_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] last;

  always_comb begin
    last   = (div_i == '0) ? '0 : div_i - DIV_W'(1);
    tick_o = run_i && (cnt_q == last);
    cnt_d  = cnt_q;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: accepts a mode/divider/pattern config, then steps
// the 8-bit LED drive once per prescaler tick while enabled.
//
//   state | meaning
//   IDLE  | frozen: LEDs and prescaler hold their values
//   LOAD  | one cycle after a config transfer; prescaler cleared
//   RUN   | prescaler counting, LEDs advance on each tick
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int DIV_W   = 24,
  parameter int RST_DIV = 12_000_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [1:0]       cfg_mode_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic [7:0]       cfg_pat_i,
  output logic [7:0]       s_o,
  output logic             step_o
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       pat_q, pat_d;
  logic [7:0]       s_q, s_d;
  logic             dir_q, dir_d;  // 0 = moving left (towards bit 7)
  logic             step_q, step_d;
  logic             xfer;
  logic             tick;

  assign cfg_ready_o = (state_q != ST_LOAD);
  assign xfer        = cfg_valid_i && cfg_ready_o;
  assign s_o         = s_q;
  assign step_o      = step_q;

  led_step_div #(.DIV_W(DIV_W)) u_step_div (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .div_i   (div_q),
    .clear_i (xfer || (state_q == ST_LOAD)),
    .run_i   (state_q == ST_RUN),
    .tick_o  (tick)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    div_d   = div_q;
    pat_d   = pat_q;
    s_d     = s_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    if (xfer) begin
      // A new config overrides any tick landing in the same cycle.
      mode_d  = mode_e'(cfg_mode_i);
      div_d   = cfg_div_i;
      pat_d   = cfg_pat_i;
      s_d     = start_val(mode_e'(cfg_mode_i), cfg_pat_i);
      dir_d   = 1'b0;
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_IDLE: if (enable_i) state_d = ST_RUN;
        ST_LOAD: state_d = enable_i ? ST_RUN : ST_IDLE;
        ST_RUN: begin
          if (tick) begin
            step_d = 1'b1;
            case (mode_q)
              MODE_COUNT: s_d = s_q + 8'd1;
              MODE_SHIFT: begin
                if (!dir_q) begin
                  if (s_q == 8'h80) begin
                    s_d   = 8'h40;
                    dir_d = 1'b1;
                  end else begin
                    s_d = s_q << 1;
                  end
                end else begin
                  if (s_q == 8'h01) begin
                    s_d   = 8'h02;
                    dir_d = 1'b0;
                  end else begin
                    s_d = s_q >> 1;
                  end
                end
              end
              MODE_BLINK: s_d = (s_q == 8'h00) ? pat_q : 8'h00;
              default:    s_d = s_q;
            endcase
          end
          if (!enable_i) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_COUNT;
      div_q   <= DIV_W'(RST_DIV);
      pat_q   <= RST_PAT;
      s_q     <= START_COUNT;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      pat_q   <= pat_d;
      s_q     <= s_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: a step-index reference model checked
// every cycle, plus directed scenarios with literal expected values.
module tb_led_seq_ctrl;

  localparam int DIV_W   = 24;
  localparam int RST_DIV = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_mode = 2'd0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [7:0]       cfg_pat = 8'h00;
  logic [7:0]       s;
  logic             step;

  int checks = 0;
  int errors = 0;

  led_seq_ctrl #(.DIV_W(DIV_W), .RST_DIV(RST_DIV)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (en),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_mode_i  (cfg_mode),
    .cfg_div_i   (cfg_div),
    .cfg_pat_i   (cfg_pat),
    .s_o         (s),
    .step_o      (step)
  );

  always #5 clk = ~clk;

  // Reference model: tracks how many steps were taken since the last load
  // and derives the LED value from the mode's rule for step n.
  int        m_phase;  // 0 idle, 1 load, 2 run
  int        m_mode, m_div, m_n, m_pc;
  logic [7:0] m_pat;
  logic      m_step;
  bit        chk_en = 1'b0;

  function automatic logic [7:0] exp_s(input int mode, input int n, input logic [7:0] pat);
    int p;
    case (mode)
      0: return 8'(n % 256);
      1: begin
        p = n % 14;
        return 8'(1 << ((p < 8) ? p : 14 - p));
      end
      2: return (n % 2 == 1) ? pat : 8'h00;
      default: return pat;
    endcase
  endfunction

  always @(posedge clk) begin
    int d;
    m_step = 1'b0;
    if (rst) begin
      m_phase = 0; m_mode = 0; m_div = RST_DIV; m_pat = 8'hFF; m_n = 0; m_pc = 0;
    end else if (cfg_valid && m_phase != 1) begin
      m_mode = int'(cfg_mode); m_div = int'(cfg_div); m_pat = cfg_pat;
      m_n = 0; m_pc = 0; m_phase = 1;
    end else begin
      case (m_phase)
        0: if (en) m_phase = 2;
        1: m_phase = en ? 2 : 0;
        default: begin
          d = (m_div == 0) ? 1 : m_div;
          m_pc++;
          if (m_pc >= d) begin
            m_pc = 0; m_n++; m_step = 1'b1;
          end
          if (!en) m_phase = 0;
        end
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      checks++;
      if (s !== exp_s(m_mode, m_n, m_pat) || step !== m_step || cfg_ready !== (m_phase != 1)) begin
        errors++;
        $display("FAIL model t=%0t: s=%02h step=%0b ready=%0b expected s=%02h step=%0b ready=%0b",
                 $time, s, step, cfg_ready, exp_s(m_mode, m_n, m_pat), m_step, (m_phase != 1));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] mode, input int dv, input logic [7:0] pat);
    cfg_valid = 1'b1; cfg_mode = mode; cfg_div = DIV_W'(dv); cfg_pat = pat;
  endtask

  logic [7:0] shift_seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  initial begin
    int pulses;
    bit saw_ff;

    // Reset, then run with the reset divider of 4
    #2;
    chk_en = 1'b1;
    rst = 1'b1;
    cyc(1);
    chk("rst_s", s, 8'h00);
    chk("rst_step", {7'd0, step}, 8'h00);
    chk("rst_ready", {7'd0, cfg_ready}, 8'h01);
    rst = 1'b0; en = 1'b1;
    cyc(4);
    chk("div4_pre", s, 8'h00);
    cyc(1);
    chk("div4_s1", s, 8'h01);
    chk("div4_step1", {7'd0, step}, 8'h01);
    cyc(1);
    chk("div4_step_low", {7'd0, step}, 8'h00);
    cyc(3);
    chk("div4_s2", s, 8'h02);
    chk("div4_step2", {7'd0, step}, 8'h01);

    // COUNT, div 3, 256 steps with wrap
    send(2'd0, 3, 8'h00);
    cyc(1);
    cfg_valid = 1'b0;
    chk("count_load_ready", {7'd0, cfg_ready}, 8'h00);
    chk("count_load_s", s, 8'h00);
    pulses = 0; saw_ff = 1'b0;
    for (int i = 0; i < 1 + 3 * 256; i++) begin
      cyc(1);
      if (step) pulses++;
      if (s == 8'hFF) saw_ff = 1'b1;
    end
    checks++;
    if (pulses != 256) begin
      errors++;
      $display("FAIL count_pulses: got %0d expected 256", pulses);
    end
    chk("count_saw_ff", {7'd0, saw_ff}, 8'h01);
    chk("count_wrap", s, 8'h00);

    // SHIFT, div 1: bounce without holding endpoints
    send(2'd1, 1, 8'h00);
    cyc(1);
    cfg_valid = 1'b0;
    chk("shift_load", s, 8'h01);
    cyc(1);
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      chk("shift_seq", s, shift_seq[i]);
    end

    // BLINK A5, div 2, freeze for 10 cycles after 3 steps
    send(2'd2, 2, 8'hA5);
    cyc(1);
    cfg_valid = 1'b0;
    chk("blink_load", s, 8'h00);
    cyc(7);
    chk("blink_3steps", s, 8'hA5);
    en = 1'b0;
    cyc(10);
    chk("blink_frozen", s, 8'hA5);
    en = 1'b1;
    cyc(1);
    chk("blink_resume1", s, 8'hA5);
    cyc(1);
    chk("blink_resume2", s, 8'h00);
    chk("blink_resume_step", {7'd0, step}, 8'h01);

    // Config coinciding with a tick, valid held through LOAD
    cyc(1);
    send(2'd3, 5, 8'h3C);
    cyc(1);
    chk("coinc_step", {7'd0, step}, 8'h00);
    chk("coinc_s", s, 8'h3C);
    chk("coinc_ready", {7'd0, cfg_ready}, 8'h00);
    send(2'd0, 2, 8'h77);
    cyc(1);
    chk("after_load_ready", {7'd0, cfg_ready}, 8'h01);
    chk("load_ignored", s, 8'h3C);
    cyc(1);
    cfg_valid = 1'b0;
    chk("second_xfer_ready", {7'd0, cfg_ready}, 8'h00);
    chk("second_xfer_s", s, 8'h00);
    cyc(5);
    chk("second_cfg_count", s, 8'h02);

    // HOLD with div 0: steps every run cycle, value constant
    send(2'd3, 0, 8'h5A);
    cyc(1);
    cfg_valid = 1'b0;
    cyc(2);
    chk("hold_div0_s", s, 8'h5A);
    chk("hold_div0_step", {7'd0, step}, 8'h01);
    cyc(3);

    // Reset mid-SHIFT while moving right at 0x10
    send(2'd1, 1, 8'h00);
    cyc(1);
    cfg_valid = 1'b0;
    cyc(11);
    chk("shift_right_10", s, 8'h10);
    rst = 1'b1;
    cyc(1);
    chk("midrst_s", s, 8'h00);
    chk("midrst_ready", {7'd0, cfg_ready}, 8'h01);
    rst = 1'b0; en = 1'b0;
    cyc(3);
    chk("midrst_idle", s, 8'h00);
    en = 1'b1;
    cyc(5);
    chk("midrst_count_mode", s, 8'h01);
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
